fsm_modexp_ctrl: RTL

Parametrised sequencer for right-to-left binary modular exponentiation around one Montgomery multiplier (MMM) datapath. It runs three kinds of MMM phase: a PRE phase (into Montgomery domain), one ITER phase per exponent bit (square always, multiply gated by the bit), and a POST phase (out of domain). Compared with the fixed 8-bit/10-bit counter decoder it replaces, it adds:
- generic operand and exponent widths;
- a start/busy/eoc handshake;
- synchronous abort;
- optional early exit when the remaining exponent bits are zero.

---
 rtl/fsm_modexp_ctrl_pkg.sv | 26 ++
 rtl/fsm_modexp_ctrl_if.sv | 47 ++++
 rtl/fsm_modexp_ctrl_seq_timer.sv | 49 ++++
 rtl/fsm_modexp_ctrl.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/fsm_modexp_ctrl_pkg.sv
// Shared types and constants for the modular-exponentiation sequencer.
// Contents:
//   phase_t  : MMM phase (IDLE, PRE, ITER, POST, DONE)
//   step_t   : step inside one phase (LOAD, RUN, STORE)
//   SEL1_*   : operand-mux codes for the MMM datapath
package rsa_pkg;

  typedef enum logic [2:0] {
    PH_IDLE = 3'd0,
    PH_PRE  = 3'd1,
    PH_ITER = 3'd2,
    PH_POST = 3'd3,
    PH_DONE = 3'd4
  } phase_t;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STORE = 2'd2
  } step_t;

  localparam logic [1:0] SEL1_INIT = 2'b00;
  localparam logic [1:0] SEL1_LOOP = 2'b01;
  localparam logic [1:0] SEL1_POST = 2'b10;

endpackage

// File: rtl/fsm_modexp_ctrl_if.sv
// Bundle of control/status signals between the exponentiation sequencer and
// whatever drives it.
//
// Handshake: the driver raises start (with expE valid in the same cycle)
// while busy=0 and eoc=0; the request is taken on that enabled edge and
// busy rises the next cycle. busy stays high until the final STORE step,
// then eoc pulses for exactly one enabled cycle. start outside IDLE is
// ignored; abort cancels a running operation without producing eoc.
//
// master: request side (drives en/start/abort/expE)
// slave : sequencer side (drives MMM controls, status and debug state)
interface fsm_modexp_ctrl_if #(
  parameter int EXP_W = 10
);
  localparam int IW = $clog2(EXP_W + 1);

  logic             en;
  logic             start;
  logic             abort;
  logic [EXP_W-1:0] expE;

  logic             rst_mmm;
  logic             ld_a;
  logic             ld_r;
  logic             lock1;
  logic             lock2;
  logic [1:0]       sel1;
  logic             sel2;
  logic             busy;
  logic             eoc;
  logic [IW-1:0]    iter_idx;

  logic [2:0]       dbg_phase;
  logic [1:0]       dbg_step;

  modport master (
    output en, start, abort, expE,
    input  rst_mmm, ld_a, ld_r, lock1, lock2, sel1, sel2, busy, eoc, iter_idx,
    input  dbg_phase, dbg_step
  );

  modport slave (
    input  en, start, abort, expE,
    output rst_mmm, ld_a, ld_r, lock1, lock2, sel1, sel2, busy, eoc, iter_idx,
    output dbg_phase, dbg_step
  );
endinterface

// File: rtl/fsm_modexp_ctrl_seq_timer.sv
// Step/cycle counter for one MMM phase (LOAD, MMM_CYC x RUN, STORE).
// Ports:
//   clk, rstb    : clock, asynchronous active-low reset
//   en_i         : clock enable; 0 freezes the counter
//   clear_i      : return to the LOAD position on the next enabled edge
//   step_o       : current step decoded from the counter
//   phase_end_o  : high during the STORE cycle (last cycle of the phase)
module modexp_seq_timer
  import rsa_pkg::*;
#(
  parameter int MMM_CYC = 10
) (
  input  logic  clk,
  input  logic  rstb,
  input  logic  en_i,
  input  logic  clear_i,
  output step_t step_o,
  output logic  phase_end_o
);

  localparam int P  = MMM_CYC + 2;
  localparam int CW = $clog2(P);
  localparam logic [CW-1:0] LAST = CW'(P - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // The counter wraps by itself so consecutive phases need no parent action.
  always_comb begin
    cnt_d = cnt_q;
    if (en_i) begin
      if (clear_i || (cnt_q == LAST)) cnt_d = '0;
      else                            cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  always_comb begin
    step_o = ST_RUN;
    if (cnt_q == '0)       step_o = ST_LOAD;
    else if (cnt_q == LAST) step_o = ST_STORE;
  end

  assign phase_end_o = (cnt_q == LAST);

endmodule

// File: rtl/fsm_modexp_ctrl.sv
// Sequencer for right-to-left binary modular exponentiation around a single
// Montgomery multiplier. Runs PRE (into Montgomery domain), one ITER per
// exponent bit (square always, multiply gated by the current bit) and POST
// (out of domain), then pulses eoc.
// Ports:
//   clk   : clock
//   rstb  : asynchronous active-low reset
//   bus   : slave side of fsm_modexp_ctrl_if
//           in : en, start, abort, expE
//           out: rst_mmm, ld_a, ld_r, lock1, lock2, sel1, sel2, busy, eoc,
//                iter_idx, dbg_phase, dbg_step
// All outputs are decoded from registered state only.
module fsm_modexp_ctrl
  import rsa_pkg::*;
#(
  parameter int OP_W       = 8,
  parameter int EXP_W      = 10,
  parameter int MMM_CYC    = OP_W + 2,
  parameter int SKIP_ZEROS = 0
) (
  input logic              clk,
  input logic              rstb,
  fsm_modexp_ctrl_if.slave bus
);

  localparam int IW = $clog2(EXP_W + 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(EXP_W);

  localparam logic [2:0] S_IDLE = PH_IDLE;
  localparam logic [2:0] S_PRE  = PH_PRE;
  localparam logic [2:0] S_ITER = PH_ITER;
  localparam logic [2:0] S_POST = PH_POST;
  localparam logic [2:0] S_DONE = PH_DONE;

  logic [2:0]       phase_q, phase_d;
  logic [EXP_W-1:0] exp_q, exp_d;
  logic [IW-1:0]    idx_q, idx_d;

  step_t            step;
  logic             phase_end;
  logic             tmr_clear;
  logic [EXP_W-1:0] exp_shift;
  logic [IW-1:0]    idx_inc;
  logic             last_iter;

  // Keep the timer parked at LOAD whenever no phase is running so the
  // first cycle after a start is always PRE/LOAD.
  assign tmr_clear = bus.abort || (phase_q == S_IDLE) || (phase_q == S_DONE);

  modexp_seq_timer #(
    .MMM_CYC (MMM_CYC)
  ) u_timer (
    .clk         (clk),
    .rstb        (rstb),
    .en_i        (bus.en),
    .clear_i     (tmr_clear),
    .step_o      (step),
    .phase_end_o (phase_end)
  );

  assign exp_shift = exp_q >> 1;
  assign idx_inc   = idx_q + 1'b1;
  // Early exit looks at the exponent after this ITER's shift.
  assign last_iter = (idx_inc == IDX_LAST) || ((SKIP_ZEROS != 0) && (exp_shift == '0));

  always_comb begin
    phase_d = phase_q;
    exp_d   = exp_q;
    idx_d   = idx_q;
    if (bus.en) begin
      if (bus.abort) begin
        if (phase_q != S_IDLE) begin
          phase_d = S_IDLE;
          exp_d   = '0;
          idx_d   = '0;
        end
      end else begin
        case (phase_q)
          S_IDLE: begin
            if (bus.start) begin
              phase_d = S_PRE;
              exp_d   = bus.expE;
              idx_d   = '0;
            end
          end
          S_PRE: begin
            if (phase_end) begin
              if ((SKIP_ZEROS == 0) || (exp_q != '0)) phase_d = S_ITER;
              else                                     phase_d = S_POST;
            end
          end
          S_ITER: begin
            if (phase_end) begin
              exp_d = exp_shift;
              idx_d = idx_inc;
              if (last_iter) phase_d = S_POST;
            end
          end
          S_POST: begin
            if (phase_end) phase_d = S_DONE;
          end
          S_DONE:  phase_d = S_IDLE;
          default: phase_d = S_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      phase_q <= S_IDLE;
      exp_q   <= '0;
      idx_q   <= '0;
    end else begin
      phase_q <= phase_d;
      exp_q   <= exp_d;
      idx_q   <= idx_d;
    end
  end

  // Moore output decode
  logic       in_op;
  logic       rst_mmm, ld_a, ld_r, lock1, lock2, sel2, busy, eoc;
  logic [1:0] sel1;

  assign in_op = (phase_q == S_PRE) || (phase_q == S_ITER) || (phase_q == S_POST);

  always_comb begin
    rst_mmm = 1'b0;
    ld_a    = 1'b0;
    ld_r    = 1'b0;
    lock1   = 1'b0;
    lock2   = 1'b0;
    sel1    = SEL1_INIT;
    sel2    = 1'b0;
    busy    = 1'b0;
    eoc     = 1'b0;
    if (in_op) begin
      busy    = 1'b1;
      rst_mmm = (step != ST_LOAD);
      ld_a    = (step == ST_LOAD);
      ld_r    = (step == ST_STORE);
    end
    case (phase_q)
      S_PRE: begin
        lock1 = 1'b1;
        lock2 = 1'b1;
      end
      S_ITER: begin
        sel1  = SEL1_LOOP;
        sel2  = 1'b1;
        lock1 = exp_q[0];
        lock2 = 1'b1;
      end
      S_POST: begin
        sel1  = SEL1_POST;
        sel2  = 1'b1;
        lock1 = 1'b1;
      end
      S_DONE:  eoc = 1'b1;
      default: ;
    endcase
  end

  assign bus.rst_mmm   = rst_mmm;
  assign bus.ld_a      = ld_a;
  assign bus.ld_r      = ld_r;
  assign bus.lock1     = lock1;
  assign bus.lock2     = lock2;
  assign bus.sel1      = sel1;
  assign bus.sel2      = sel2;
  assign bus.busy      = busy;
  assign bus.eoc       = eoc;
  assign bus.iter_idx  = idx_q;
  assign bus.dbg_phase = phase_q;
  assign bus.dbg_step  = step;

endmodule
